// File: rtl/outlier_writeback_pkg.sv
// Shared definitions for the outlier writeback block: FSM states, default
// widths and the per-word address increment.
package outlier_writeback_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } wb_state_t;

  localparam int unsigned DEF_POS_W  = 16;
  localparam int unsigned DEF_ADDR_W = 32;

  // Byte step between consecutive packed words of two positions.
  function automatic int unsigned addr_step(input int unsigned pos_w);
    return (2 * pos_w) / 8;
  endfunction

endpackage

// File: rtl/outlier_pack_stage.sv
// Pairs returned FIFO positions into 2N-bit words: pack register, one-entry
// skid for data returned while the output is stalled, and a valid/ready output.
module outlier_pack_stage
  import outlier_writeback_pkg::*;
#(
  parameter int unsigned N = DEF_POS_W
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           i_clear,
  input  logic           i_pos_valid,
  input  logic [N-1:0]   i_pos,
  input  logic           i_pad,
  input  logic           i_out_ready,
  output logic           o_skid_full,
  output logic           o_pack_full,
  output logic           o_out_valid,
  output logic [2*N-1:0] o_out_data,
  output logic           o_accept
);

  localparam logic [N-1:0] PAD = '1;

  logic           r_pack_v;
  logic           r_skid_v;
  logic           r_out_v;
  logic [N-1:0]   r_pack;
  logic [N-1:0]   r_skid;
  logic [2*N-1:0] r_out;

  logic           w_in_valid;
  logic [N-1:0]   w_in;
  logic           w_out_free;
  logic           w_accept;

  // The skid is never full while a read returns, so it simply takes priority.
  assign w_in_valid = r_skid_v | i_pos_valid;
  assign w_in       = r_skid_v ? r_skid : i_pos;
  assign w_accept   = r_out_v & i_out_ready;
  assign w_out_free = ~r_out_v | i_out_ready;

  always_ff @(posedge clock) begin
    if (!reset || i_clear) begin
      r_pack_v <= 1'b0;
      r_skid_v <= 1'b0;
      r_out_v  <= 1'b0;
      r_pack   <= '0;
      r_skid   <= '0;
      r_out    <= '0;
    end else begin
      if (w_accept)
        r_out_v <= 1'b0;
      if (w_in_valid) begin
        if (!r_pack_v) begin
          r_pack   <= w_in;
          r_pack_v <= 1'b1;
          r_skid_v <= 1'b0;
        end else if (w_out_free) begin
          r_out    <= {w_in, r_pack};
          r_out_v  <= 1'b1;
          r_pack_v <= 1'b0;
          r_skid_v <= 1'b0;
        end else begin
          r_skid   <= w_in;
          r_skid_v <= 1'b1;
        end
      end else if (i_pad && r_pack_v && w_out_free) begin
        r_out    <= {PAD, r_pack};
        r_out_v  <= 1'b1;
        r_pack_v <= 1'b0;
      end
    end
  end

  assign o_skid_full = r_skid_v;
  assign o_pack_full = r_pack_v;
  assign o_out_valid = r_out_v;
  assign o_out_data  = r_out;
  assign o_accept    = w_accept;

endmodule

// File: rtl/outlier_writeback.sv
// Drains the outlier-position FIFO and writes packed position pairs to
// consecutive memory words starting at a programmable base address.
module outlier_writeback
  import outlier_writeback_pkg::*;
#(
  parameter int unsigned N      = DEF_POS_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              ctrl_done,
  input  logic [N-1:0]      fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2*N-1:0]    mem_wdata,
  output logic [N-1:0]      outlier_count,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(addr_step(N));

  wb_state_t         r_state;
  wb_state_t         w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [N-1:0]      r_count;
  logic              r_inflight;
  logic              r_guard;

  logic              w_rd_en;
  logic              w_start_ok;
  logic              w_guard_now;
  logic              w_skid_full;
  logic              w_pack_full;
  logic              w_out_valid;
  logic [2*N-1:0]    w_out_data;
  logic              w_accept;

  assign w_start_ok  = start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_guard_now = ctrl_done && fifo_empty;

  outlier_pack_stage #(.N(N)) u_pack (
    .clock       (clock),
    .reset       (reset),
    .i_clear     (w_start_ok),
    .i_pos_valid (r_inflight),
    .i_pos       (fifo_dout),
    .i_pad       (r_state == ST_FLUSH),
    .i_out_ready (mem_ready),
    .o_skid_full (w_skid_full),
    .o_pack_full (w_pack_full),
    .o_out_valid (w_out_valid),
    .o_out_data  (w_out_data),
    .o_accept    (w_accept)
  );

  always_comb begin
    w_next  = r_state;
    w_rd_en = 1'b0;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_RUN;
      ST_RUN: begin
        w_rd_en = !fifo_empty && !w_skid_full && !(w_out_valid && !mem_ready);
        // End of stream needs the done+empty condition held for two cycles.
        if (r_guard && w_guard_now && !r_inflight && !w_skid_full)
          w_next = ST_FLUSH;
      end
      ST_FLUSH: if (!w_pack_full && (!w_out_valid || w_accept)) w_next = ST_DONE;
      ST_DONE: if (start) w_next = ST_RUN;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_count    <= '0;
      r_inflight <= 1'b0;
      r_guard    <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_inflight <= w_rd_en;
      r_guard    <= (r_state == ST_RUN) && w_guard_now;
      if (w_start_ok) begin
        r_addr  <= base_addr;
        r_count <= '0;
      end else begin
        if (w_accept)
          r_addr <= r_addr + STEP;
        if (r_inflight && r_count != '1)
          r_count <= r_count + 1'b1;
      end
    end
  end

  assign fifo_rd_en    = w_rd_en;
  assign mem_valid     = w_out_valid;
  assign mem_addr      = r_addr;
  assign mem_wdata     = w_out_data;
  assign outlier_count = r_count;
  assign busy          = (r_state == ST_RUN) || (r_state == ST_FLUSH);
  assign done          = (r_state == ST_DONE);

endmodule

// File: doc/outlier_writeback.md
# outlier_writeback

Drains the outlier-position FIFO filled by the point-validation controller and writes the positions to memory as packed 2N-bit words at consecutive addresses from a programmable base. It is the consumer end of the outlier FIFO: it drives the FIFO read enable, tracks the one-cycle read latency, and absorbs memory back-pressure without over-reading. It detects end of stream from the controller's done flag plus a drained FIFO, pads an odd trailing position, and reports the outlier count.

## Interface
- N, 16, point-position width (FIFO dout width)
- ADDR_W, 32, memory byte-address width
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse; latches base_addr and begins draining
- base_addr  in  ADDR_W  byte address of first output word
- ctrl_done  in  1  controller done level (no more FIFO writes will follow)
- fifo_dout  in  N  FIFO read data, valid the cycle after fifo_rd_en
- fifo_empty  in  1  FIFO empty flag
- fifo_rd_en  out  1  FIFO pop request
- mem_valid  out  1  write request valid
- mem_ready  in  1  write accepted when mem_valid && mem_ready
- mem_addr  out  ADDR_W  write byte address
- mem_wdata  out  2N  packed positions: first [N-1:0], second [2N-1:N]
- outlier_count  out  N  positions popped since start, saturating at 2^N-1
- busy  out  1  high in RUN and FLUSH
- done  out  1  level, high in DONE until next start or reset

## Operation
- States: IDLE, RUN, FLUSH, DONE. Reset -> IDLE.
- IDLE/DONE + start -> RUN: addr_reg <= base_addr, outlier_count <= 0, pack/skid/output cleared, done <= 0. start in RUN/FLUSH is ignored.
- fifo_rd_en = RUN && !fifo_empty && skid empty && !(mem_valid && !mem_ready). At most one read in flight.
- Returned position (cycle after rd_en): if pack empty -> pack_lo; if pack full and output register free (mem_valid low, or accepted this cycle) -> output word {dout, pack_lo}, pack cleared; otherwise -> skid. Skid is drained before any newer data, same placement rules. FIFO order is preserved into memory.
- outlier_count increments once per returned position, saturates.
- Accepted write: addr_reg += 2N/8 (wraps modulo 2^ADDR_W); mem_valid drops unless a new word is loaded the same cycle.
- RUN -> FLUSH: ctrl_done && fifo_empty on two consecutive cycles, no read in flight, skid empty.
- FLUSH: if pack holds one position, load {all-ones, pack_lo} when output register is free; when output register empty and pack empty -> DONE.
- Zero outliers: no writes issued, DONE reached via FLUSH.

## Timing
- Reset values: fifo_rd_en 0, mem_valid 0, mem_addr 0, mem_wdata 0, outlier_count 0, busy 0, done 0.
- rd_en at t -> position captured at edge ending t+1; pair complete -> mem_valid high from the next cycle.
- Sustained throughput with mem_ready=1: one position per cycle after fill.
- While mem_valid && !mem_ready: mem_addr and mem_wdata held stable, mem_valid stays high.
- fifo_empty deasserting after ctrl_done rises restarts the two-cycle empty guard; the late position is written.
- Reset in any state: immediate return to reset values; an un-accepted write is abandoned; in-flight FIFO data is discarded.
- DONE -> done asserted the cycle after the last write is accepted (or after FLUSH with nothing pending).

## Structure
- Shared package: state encoding (IDLE/RUN/FLUSH/DONE), pad constant (all-ones N bits), address step 2N/8.
- One natural sub-module: outlier_pack_stage (pack register + skid + output register with valid/ready), FSM and address counter in top.

## Test plan
- FIFO 3,7,9,12, ctrl_done=1, mem_ready=1, base 0x1000 -> writes 0x000C0009? no: 0x00070003@0x1000, 0x000C0009@0x1004; outlier_count 4; done.
- FIFO 5,6,8 -> 0x00060005@0x1000, 0xFFFF0008@0x1004; count 3.
- Six positions, mem_ready low 10 cycles mid-stream -> mem_addr/mem_wdata stable, no rd_en while stalled with skid full, order intact.
- ctrl_done=1, FIFO empty throughout -> no mem_valid, done after guard, count 0.
- ctrl_done rises, fifo_empty drops one cycle later with position 42 -> 0xFFFF002A written before done.
- Reset asserted during a stalled write -> all outputs to reset values; new start with base 0x2000 writes from 0x2000.
